regfile_write_sched: RTL and testbench
======================================

Name: regfile_write_sched

Overview:
- Write-port scheduler for the dual-write-port register file (ports c and d).
- Shares the two write ports between NUM_REQ producers (functional units, load return, etc.) using valid/ready handshakes and round-robin priority.
- Registers the chosen writes into a one-deep stage that drives the regfile write ports.
- Exports a pending-write mask so read-side logic can stall on RAW hazards.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ADDR_WIDTH, 4, register address width (16 registers = REG_CNT*SUPERSCALAR_WIDTH at defaults).
- REG_WIDTH, 288, data width per register.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- freeze  in  1  global pipeline freeze.
- req_valid  in  NUM_REQ  per-requester write request.
- req_addr  in  NUM_REQ*ADDR_WIDTH  packed addresses; requester i at [i*ADDR_WIDTH +: ADDR_WIDTH].
- req_data  in  NUM_REQ*REG_WIDTH  packed write data.
- req_ready  out  NUM_REQ  grant; a transfer occurs when valid&&ready.
- port_c_we  out  1  regfile port c write enable.
- port_c_write_addr  out  ADDR_WIDTH  port c address.
- port_c_in  out  REG_WIDTH  port c data.
- port_d_we  out  1  regfile port d write enable.
- port_d_write_addr  out  ADDR_WIDTH  port d address.
- port_d_in  out  REG_WIDTH  port d data.
- pending_mask  out  2**ADDR_WIDTH  bit r set while a write to r sits in the stage.
- stall_cycles  out  32  contention counter (see Optional Feature).

Behaviour:
- Reset: all port_* outputs 0, req_ready 0, pending_mask 0, rr_ptr 0, stall_cycles 0.
- req_ready is combinational from req_valid, rr_ptr and freeze. Requesters hold valid/addr/data stable until granted.
- Selection, combinational each cycle with freeze=0:
  - Winner C: first i with req_valid[i], scanning i = rr_ptr, rr_ptr+1, … mod NUM_REQ.
  - Winner D: next valid requester after C in the same scan order whose address differs from C's address.
  - Same-address conflict: the later requester is not granted this cycle; its request stays pending.
- Grants: req_ready is set only for winners; at most 2 bits set per cycle.
- Stage register, updated at posedge when not frozen:
  - port_c_we/port_d_we = winner present.
  - Address and data captured from the winner; unused port has we=0, addr/data hold previous values.
- Latency: request granted in cycle N → regfile write enable asserted in cycle N+1 → data readable through the regfile's one-cycle read path from cycle N+2.
- pending_mask: computed from stage contents; bit set iff port_c_we or port_d_we is asserted for that address.
- Round-robin pointer: at posedge, rr_ptr = (index of last granted requester + 1) mod NUM_REQ. Held when there is no grant.
- Freeze=1:
  - req_ready forced to 0.
  - Stage, rr_ptr and stall_cycles held; port_*_we stays at its held value. The regfile's own freeze blocks the write.
- Freeze and reset together: reset wins.
- WAW ordering: a request to an address already in the stage is legal. The stage commits first, the newer write lands one cycle later, so program order per requester is preserved.
- Single requester: only port c is used; port d stays idle.
- NUM_REQ=2, both valid, same address: one grant per cycle, alternating by rr_ptr.

Optional Feature:
- Macro: REGFILE_WSCHED_STATS_EN.
- Defined:
  - stall_cycles increments (saturating at 2^32-1) on every non-frozen cycle in which some req_valid bit is set but its req_ready is 0.
  - Cleared by reset.
- Undefined: stall_cycles tied to 0 and no counter logic is synthesized.

Decomposition:
- Package regfile_pkg:
  - REG_WIDTH and ADDR_WIDTH defaults.
  - Typedef wr_req_t {addr, data}.
  - Typedef wr_port_t {we, addr, data}.
- Sub-module rr_pick: combinational find-first-from-pointer over a NUM_REQ mask.
  - Instance 1 picks C.
  - Instance 2 picks D, with C and C's same-address requesters masked out.

Test Plan:
1. Reset → all outputs 0, pending_mask 0. Then req 0 valid, addr 15, data 2 → req_ready[0] in the same cycle; next cycle port_c_we=1, addr 15, data 2, pending_mask[15]=1.
2. Reqs 0–3 all valid, addrs 1,2,3,4, rr_ptr=0 → cycle 1 grants 0 (C) and 1 (D); cycle 2 grants 2 and 3; rr_ptr back to 0.
3. Reqs 1 and 2 both valid to addr 7 → only req 1 granted; req 2 granted next cycle. Port c writes 7 in two consecutive cycles, in order.
4. Freeze=1 for 3 cycles with reqs valid and stage holding addr 5 → req_ready=0, stage and port_c_we held, rr_ptr unchanged. Grants resume the cycle freeze drops.
5. Reset asserted mid-stream with freeze=1 and both ports writing → next cycle we=0, pending_mask 0, rr_ptr 0.
6. With REGFILE_WSCHED_STATS_EN and scenario 3 → stall_cycles=1. Without the macro → stall_cycles stays 0.

Source files
------------

// File: rtl/regfile_write_sched_pkg.sv
// Shared types and defaults for the regfile write-port scheduler.
// Optional build macro used by the scheduler: REGFILE_WSCHED_STATS_EN.
package regfile_pkg;

    localparam int RF_NUM_REQ    = 4;
    localparam int RF_ADDR_WIDTH = 4;
    localparam int RF_REG_WIDTH  = 288;

    // One producer's write request at default widths.
    typedef struct packed {
        logic [RF_ADDR_WIDTH-1:0] addr;
        logic [RF_REG_WIDTH-1:0]  data;
    } wr_req_t;

    // One regfile write port at default widths.
    typedef struct packed {
        logic                     we;
        logic [RF_ADDR_WIDTH-1:0] addr;
        logic [RF_REG_WIDTH-1:0]  data;
    } wr_port_t;

    // Increment an index modulo n.
    function automatic int wrap_inc(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/regfile_write_sched_if.sv
// Request bus (producers -> scheduler) and regfile write ports c/d.
// master = producer/regfile side, slave = scheduler.
interface regfile_write_sched_if
    import regfile_pkg::*;
#(
    parameter int NUM_REQ    = RF_NUM_REQ,
    parameter int ADDR_WIDTH = RF_ADDR_WIDTH,
    parameter int REG_WIDTH  = RF_REG_WIDTH
);
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
    logic [NUM_REQ*REG_WIDTH-1:0]  req_data;
    logic [NUM_REQ-1:0]            req_ready;

    logic                  port_c_we;
    logic [ADDR_WIDTH-1:0] port_c_write_addr;
    logic [REG_WIDTH-1:0]  port_c_in;
    logic                  port_d_we;
    logic [ADDR_WIDTH-1:0] port_d_write_addr;
    logic [REG_WIDTH-1:0]  port_d_in;

    modport master (
        output req_valid, req_addr, req_data,
        input  req_ready,
        input  port_c_we, port_c_write_addr, port_c_in,
        input  port_d_we, port_d_write_addr, port_d_in
    );

    modport slave (
        input  req_valid, req_addr, req_data,
        output req_ready,
        output port_c_we, port_c_write_addr, port_c_in,
        output port_d_we, port_d_write_addr, port_d_in
    );
endinterface

// File: rtl/regfile_write_sched_rr_pick.sv
// Find-first set bit of a mask, scanning upward from a pointer with wrap.
module rr_pick #(
    parameter  int N  = 4,
    localparam int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  mask_i,
    input  logic [PW-1:0] ptr_i,
    output logic          found_o,
    output logic [PW-1:0] idx_o
);

    // Scan ptr, ptr+1, ... mod N and report the first set position.
    always_comb begin
        logic        hit;
        int unsigned pos;
        // NOTE: every output gets a default before the loop so no path can infer a latch.
        hit   = 1'b0;
        idx_o = '0;
        for (int k = 0; k < N; k++) begin
            pos = (int'(ptr_i) + k) % N;
            if (!hit && mask_i[pos]) begin
                hit   = 1'b1;
                idx_o = PW'(pos);
            end
        end
        found_o = hit;
    end

endmodule

// File: rtl/regfile_write_sched.sv
// Dual write-port scheduler: round-robin selection of up to two producers
// per cycle into a one-deep stage driving regfile ports c and d.
// Build macro REGFILE_WSCHED_STATS_EN enables the contention counter.
module regfile_write_sched
    import regfile_pkg::*;
#(
    parameter int NUM_REQ    = RF_NUM_REQ,
    parameter int ADDR_WIDTH = RF_ADDR_WIDTH,
    parameter int REG_WIDTH  = RF_REG_WIDTH
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       freeze,
    regfile_write_sched_if.slave       bus,
    output logic [2**ADDR_WIDTH-1:0]   pending_mask,
    output logic [31:0]                stall_cycles
);

    localparam int PW = $clog2(NUM_REQ);

    typedef struct packed {
        logic                  we;
        logic [ADDR_WIDTH-1:0] addr;
        logic [REG_WIDTH-1:0]  data;
    } stage_t;

    stage_t          port_c_q, port_c_d;
    stage_t          port_d_q, port_d_d;
    logic [PW-1:0]   rr_ptr_q, rr_ptr_d;

    logic                  c_found, d_found;
    logic [PW-1:0]         c_idx, d_idx;
    logic [ADDR_WIDTH-1:0] c_addr;
    logic [NUM_REQ-1:0]    d_mask;

    rr_pick #(.N(NUM_REQ)) u_pick_c (
        .mask_i  (bus.req_valid),
        .ptr_i   (rr_ptr_q),
        .found_o (c_found),
        .idx_o   (c_idx)
    );

    // Port d candidates: valid requesters whose address differs from C's
    // (this also excludes C itself and holds back same-address followers).
    always_comb begin
        c_addr = bus.req_addr[int'(c_idx)*ADDR_WIDTH +: ADDR_WIDTH];
        d_mask = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            d_mask[i] = c_found && bus.req_valid[i]
                        && (bus.req_addr[i*ADDR_WIDTH +: ADDR_WIDTH] != c_addr);
        end
    end

    rr_pick #(.N(NUM_REQ)) u_pick_d (
        .mask_i  (d_mask),
        .ptr_i   (rr_ptr_q),
        .found_o (d_found),
        .idx_o   (d_idx)
    );

    // Grants, next stage contents and next pointer; everything holds under freeze.
    always_comb begin
        bus.req_ready = '0;
        port_c_d      = port_c_q;
        port_d_d      = port_d_q;
        rr_ptr_d      = rr_ptr_q;
        if (!freeze) begin
            port_c_d.we = c_found;
            port_d_d.we = d_found;
            if (c_found) begin
                bus.req_ready[c_idx] = 1'b1;
                port_c_d.addr        = c_addr;
                port_c_d.data        = bus.req_data[int'(c_idx)*REG_WIDTH +: REG_WIDTH];
                rr_ptr_d             = PW'(wrap_inc(int'(c_idx), NUM_REQ));
            end
            if (d_found) begin
                bus.req_ready[d_idx] = 1'b1;
                port_d_d.addr        = bus.req_addr[int'(d_idx)*ADDR_WIDTH +: ADDR_WIDTH];
                port_d_d.data        = bus.req_data[int'(d_idx)*REG_WIDTH +: REG_WIDTH];
                rr_ptr_d             = PW'(wrap_inc(int'(d_idx), NUM_REQ));
            end
        end
    end

    // Stage and round-robin pointer registers; reset has priority over freeze.
    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: the wide data fields are reset too so the port outputs read 0 after reset.
            port_c_q <= '0;
            port_d_q <= '0;
            rr_ptr_q <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            port_c_q <= port_c_d;
            port_d_q <= port_d_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    assign bus.port_c_we         = port_c_q.we;
    assign bus.port_c_write_addr = port_c_q.addr;
    assign bus.port_c_in         = port_c_q.data;
    assign bus.port_d_we         = port_d_q.we;
    assign bus.port_d_write_addr = port_d_q.addr;
    assign bus.port_d_in         = port_d_q.data;

    // Registers with a write in flight, for RAW stall detection on the read side.
    always_comb begin
        pending_mask = '0;
        if (port_c_q.we) pending_mask[port_c_q.addr] = 1'b1;
        if (port_d_q.we) pending_mask[port_d_q.addr] = 1'b1;
    end

`ifdef REGFILE_WSCHED_STATS_EN
    logic [31:0] stall_q, stall_d;

    // Count unfrozen cycles where some valid requester was refused; saturates.
    always_comb begin
        stall_d = stall_q;
        if (!freeze && (|(bus.req_valid & ~bus.req_ready)) && (stall_q != '1)) begin
            stall_d = stall_q + 32'd1;
        end
    end

    // Contention counter register.
    always_ff @(posedge clk) begin
        if (reset) stall_q <= '0;
        else       stall_q <= stall_d;
    end

    assign stall_cycles = stall_q;
`else
    assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_regfile_write_sched.sv
// Self-checking bench for regfile_write_sched: directed scenarios plus a
// randomized run against a scan-order reference model.
// Stall expectations follow REGFILE_WSCHED_STATS_EN.
module tb_regfile_write_sched;
    import regfile_pkg::*;

    localparam int N  = 4;
    localparam int AW = 4;
    localparam int RW = 288;

    logic clk;
    logic reset;
    logic freeze;
    logic [2**AW-1:0] pending_mask;
    logic [31:0]      stall_cycles;

    regfile_write_sched_if #(.NUM_REQ(N), .ADDR_WIDTH(AW), .REG_WIDTH(RW)) bus ();

    regfile_write_sched #(.NUM_REQ(N), .ADDR_WIDTH(AW), .REG_WIDTH(RW)) dut (
        .clk          (clk),
        .reset        (reset),
        .freeze       (freeze),
        .bus          (bus),
        .pending_mask (pending_mask),
        .stall_cycles (stall_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    logic [N-1:0] v;
    wr_req_t      rq [N];

    function automatic logic [RW-1:0] rand_data();
        logic [RW-1:0] r;
        for (int w = 0; w < RW / 32; w++) r[w*32 +: 32] = $urandom();
        return r;
    endfunction

    task automatic drive_reqs();
        for (int i = 0; i < N; i++) begin
            bus.req_valid[i]            = v[i];
            bus.req_addr[i*AW +: AW]    = rq[i].addr;
            bus.req_data[i*RW +: RW]    = rq[i].data;
        end
    endtask

    task automatic set_req(input int i, input logic [AW-1:0] addr, input logic [RW-1:0] data);
        v[i]        = 1'b1;
        rq[i].addr  = addr;
        rq[i].data  = data;
    endtask

    task automatic clear_reqs();
        v = '0;
        for (int i = 0; i < N; i++) rq[i] = '0;
        drive_reqs();
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset  = 1'b1;
        freeze = 1'b0;
        clear_reqs();
        tick();
        tick();
        reset = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        logic [RW-1:0] d15;
        apply_reset();
        n_cmp++; if (bus.port_c_we !== 1'b0) begin n_err++; $display("FAIL rst_c_we: got %b want 0", bus.port_c_we); end
        n_cmp++; if (bus.port_d_we !== 1'b0) begin n_err++; $display("FAIL rst_d_we: got %b want 0", bus.port_d_we); end
        n_cmp++; if (bus.port_c_write_addr !== 4'd0) begin n_err++; $display("FAIL rst_c_addr: got %0h want 0", bus.port_c_write_addr); end
        n_cmp++; if (bus.port_d_in !== '0) begin n_err++; $display("FAIL rst_d_data: got %0h want 0", bus.port_d_in); end
        n_cmp++; if (pending_mask !== 16'h0000) begin n_err++; $display("FAIL rst_pending: got %h want 0000", pending_mask); end
        n_cmp++; if (bus.req_ready !== 4'b0000) begin n_err++; $display("FAIL rst_ready: got %b want 0000", bus.req_ready); end
        n_cmp++; if (stall_cycles !== 32'd0) begin n_err++; $display("FAIL rst_stall: got %0d want 0", stall_cycles); end
        // Single requester, addr 15, data 2.
        d15 = RW'(2);
        set_req(0, 4'd15, d15);
        drive_reqs(); #1;
        n_cmp++; if (bus.req_ready !== 4'b0001) begin n_err++; $display("FAIL single_ready: got %b want 0001", bus.req_ready); end
        tick(); v[0] = 1'b0; drive_reqs();
        n_cmp++; if (bus.port_c_we !== 1'b1) begin n_err++; $display("FAIL single_c_we: got %b want 1", bus.port_c_we); end
        n_cmp++; if (bus.port_c_write_addr !== 4'd15) begin n_err++; $display("FAIL single_c_addr: got %0d want 15", bus.port_c_write_addr); end
        n_cmp++; if (bus.port_c_in !== d15) begin n_err++; $display("FAIL single_c_data: got %0h want 2", bus.port_c_in); end
        n_cmp++; if (bus.port_d_we !== 1'b0) begin n_err++; $display("FAIL single_d_idle: got %b want 0", bus.port_d_we); end
        n_cmp++; if (pending_mask !== 16'h8000) begin n_err++; $display("FAIL single_pending: got %h want 8000", pending_mask); end
        tick();
        n_cmp++; if (bus.port_c_we !== 1'b0) begin n_err++; $display("FAIL idle_c_we: got %b want 0", bus.port_c_we); end
        n_cmp++; if (bus.port_c_write_addr !== 4'd15) begin n_err++; $display("FAIL idle_c_addr_hold: got %0d want 15", bus.port_c_write_addr); end
        n_cmp++; if (pending_mask !== 16'h0000) begin n_err++; $display("FAIL idle_pending: got %h want 0000", pending_mask); end
    endtask

    task automatic test_four_way();
        logic [RW-1:0] dd [N];
        apply_reset();
        for (int i = 0; i < N; i++) begin
            dd[i] = rand_data();
            set_req(i, AW'(i + 1), dd[i]);
        end
        drive_reqs(); #1;
        n_cmp++; if (bus.req_ready !== 4'b0011) begin n_err++; $display("FAIL four_ready1: got %b want 0011", bus.req_ready); end
        tick(); v[0] = 1'b0; v[1] = 1'b0; drive_reqs(); #1;
        n_cmp++; if (bus.port_c_write_addr !== 4'd1 || bus.port_c_we !== 1'b1) begin n_err++; $display("FAIL four_c1: got we=%b addr=%0d want we=1 addr=1", bus.port_c_we, bus.port_c_write_addr); end
        n_cmp++; if (bus.port_d_write_addr !== 4'd2 || bus.port_d_we !== 1'b1) begin n_err++; $display("FAIL four_d1: got we=%b addr=%0d want we=1 addr=2", bus.port_d_we, bus.port_d_write_addr); end
        n_cmp++; if (bus.port_c_in !== dd[0]) begin n_err++; $display("FAIL four_c1_data: got %0h want %0h", bus.port_c_in, dd[0]); end
        n_cmp++; if (bus.port_d_in !== dd[1]) begin n_err++; $display("FAIL four_d1_data: got %0h want %0h", bus.port_d_in, dd[1]); end
        n_cmp++; if (pending_mask !== 16'h0006) begin n_err++; $display("FAIL four_pending1: got %h want 0006", pending_mask); end
        n_cmp++; if (bus.req_ready !== 4'b1100) begin n_err++; $display("FAIL four_ready2: got %b want 1100", bus.req_ready); end
        tick(); v[2] = 1'b0; v[3] = 1'b0; drive_reqs();
        n_cmp++; if (bus.port_c_write_addr !== 4'd3 || bus.port_d_write_addr !== 4'd4) begin n_err++; $display("FAIL four_addr2: got c=%0d d=%0d want c=3 d=4", bus.port_c_write_addr, bus.port_d_write_addr); end
        n_cmp++; if (bus.port_c_in !== dd[2] || bus.port_d_in !== dd[3]) begin n_err++; $display("FAIL four_data2: got c=%0h d=%0h want c=%0h d=%0h", bus.port_c_in, bus.port_d_in, dd[2], dd[3]); end
        n_cmp++; if (pending_mask !== 16'h0018) begin n_err++; $display("FAIL four_pending2: got %h want 0018", pending_mask); end
        // Pointer wrapped to 0: a fresh full set grants 0 and 1 again.
        for (int i = 0; i < N; i++) set_req(i, AW'(i + 5), rand_data());
        drive_reqs(); #1;
        n_cmp++; if (bus.req_ready !== 4'b0011) begin n_err++; $display("FAIL four_ptr_wrap: got %b want 0011", bus.req_ready); end
        clear_reqs();
    endtask

    task automatic test_same_addr();
        logic [RW-1:0] da, db;
        logic [31:0]   exp_stall;
        apply_reset();
        da = rand_data();
        db = rand_data();
        set_req(1, 4'd7, da);
        set_req(2, 4'd7, db);
        drive_reqs(); #1;
        n_cmp++; if (bus.req_ready !== 4'b0010) begin n_err++; $display("FAIL same_ready1: got %b want 0010", bus.req_ready); end
        tick(); v[1] = 1'b0; drive_reqs(); #1;
        n_cmp++; if (bus.port_c_we !== 1'b1 || bus.port_c_write_addr !== 4'd7 || bus.port_c_in !== da) begin n_err++; $display("FAIL same_first: got we=%b addr=%0d data=%0h want we=1 addr=7 data=%0h", bus.port_c_we, bus.port_c_write_addr, bus.port_c_in, da); end
        n_cmp++; if (bus.port_d_we !== 1'b0) begin n_err++; $display("FAIL same_d_idle: got %b want 0", bus.port_d_we); end
        n_cmp++; if (bus.req_ready !== 4'b0100) begin n_err++; $display("FAIL same_ready2: got %b want 0100", bus.req_ready); end
        tick(); v[2] = 1'b0; drive_reqs();
        n_cmp++; if (bus.port_c_we !== 1'b1 || bus.port_c_write_addr !== 4'd7 || bus.port_c_in !== db) begin n_err++; $display("FAIL same_second: got we=%b addr=%0d data=%0h want we=1 addr=7 data=%0h", bus.port_c_we, bus.port_c_write_addr, bus.port_c_in, db); end
        n_cmp++; if (pending_mask !== 16'h0080) begin n_err++; $display("FAIL same_pending: got %h want 0080", pending_mask); end
`ifdef REGFILE_WSCHED_STATS_EN
        exp_stall = 32'd1;
`else
        exp_stall = 32'd0;
`endif
        n_cmp++; if (stall_cycles !== exp_stall) begin n_err++; $display("FAIL same_stall: got %0d want %0d", stall_cycles, exp_stall); end
    endtask

    task automatic test_freeze();
        logic [RW-1:0] dx;
        logic [31:0]   stall_before;
        apply_reset();
        dx = rand_data();
        set_req(0, 4'd5, dx);
        drive_reqs(); #1;
        tick(); v[0] = 1'b0;
        set_req(1, 4'd9, rand_data());
        set_req(2, 4'd10, rand_data());
        freeze = 1'b1;
        drive_reqs();
        stall_before = stall_cycles;
        for (int k = 0; k < 3; k++) begin
            #1;
            n_cmp++; if (bus.req_ready !== 4'b0000) begin n_err++; $display("FAIL frz_ready%0d: got %b want 0000", k, bus.req_ready); end
            tick();
            n_cmp++; if (bus.port_c_we !== 1'b1 || bus.port_c_write_addr !== 4'd5 || bus.port_c_in !== dx) begin n_err++; $display("FAIL frz_hold%0d: got we=%b addr=%0d want we=1 addr=5", k, bus.port_c_we, bus.port_c_write_addr); end
            n_cmp++; if (bus.port_d_we !== 1'b0 || pending_mask !== 16'h0020) begin n_err++; $display("FAIL frz_pend%0d: got d_we=%b mask=%h want 0 0020", k, bus.port_d_we, pending_mask); end
            n_cmp++; if (stall_cycles !== stall_before) begin n_err++; $display("FAIL frz_stall%0d: got %0d want %0d", k, stall_cycles, stall_before); end
        end
        freeze = 1'b0; #1;
        n_cmp++; if (bus.req_ready !== 4'b0110) begin n_err++; $display("FAIL frz_resume_ready: got %b want 0110", bus.req_ready); end
        tick(); v[1] = 1'b0; v[2] = 1'b0; drive_reqs();
        n_cmp++; if (bus.port_c_write_addr !== 4'd9 || bus.port_d_write_addr !== 4'd10 || pending_mask !== 16'h0600) begin n_err++; $display("FAIL frz_resume_stage: got c=%0d d=%0d mask=%h want c=9 d=10 mask=0600", bus.port_c_write_addr, bus.port_d_write_addr, pending_mask); end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        set_req(0, 4'd3, rand_data());
        set_req(1, 4'd4, rand_data());
        drive_reqs(); #1;
        tick(); v = '0;
        set_req(2, 4'd6, rand_data());
        drive_reqs();
        n_cmp++; if (bus.port_c_we !== 1'b1 || bus.port_d_we !== 1'b1) begin n_err++; $display("FAIL mid_both_writing: got c=%b d=%b want 1 1", bus.port_c_we, bus.port_d_we); end
        freeze = 1'b1;
        reset  = 1'b1;
        tick();
        n_cmp++; if (bus.port_c_we !== 1'b0 || bus.port_d_we !== 1'b0) begin n_err++; $display("FAIL mid_we: got c=%b d=%b want 0 0", bus.port_c_we, bus.port_d_we); end
        n_cmp++; if (pending_mask !== 16'h0000) begin n_err++; $display("FAIL mid_pending: got %h want 0000", pending_mask); end
        n_cmp++; if (bus.req_ready !== 4'b0000) begin n_err++; $display("FAIL mid_ready: got %b want 0000", bus.req_ready); end
        reset  = 1'b0;
        freeze = 1'b0;
        v = '0;
        set_req(1, 4'd1, rand_data());
        set_req(2, 4'd2, rand_data());
        set_req(3, 4'd3, rand_data());
        drive_reqs(); #1;
        n_cmp++; if (bus.req_ready !== 4'b0110) begin n_err++; $display("FAIL mid_ptr_zero: got %b want 0110", bus.req_ready); end
        clear_reqs();
    endtask

    task automatic test_random();
        int            m_ptr, c, d, idx;
        logic [N-1:0]  exp_rdy;
        logic          frz;
        wr_port_t      m_c, m_d;
        logic [15:0]   m_pend;
        logic [31:0]   m_stall;
        apply_reset();
        m_ptr   = 0;
        m_c     = '0;
        m_d     = '0;
        m_stall = '0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            for (int i = 0; i < N; i++) begin
                if (!v[i] && $urandom_range(1, 0) == 1) begin
                    rq[i].addr = ($urandom_range(3, 0) == 0) ? 4'($urandom_range(15, 0)) : 4'($urandom_range(3, 0));
                    rq[i].data = rand_data();
                    v[i]       = 1'b1;
                end
            end
            frz    = ($urandom_range(7, 0) == 0);
            freeze = frz;
            drive_reqs(); #1;
            // Reference: scan requesters from the pointer; first valid goes to
            // port c, the next valid one with a different address to port d.
            exp_rdy = '0;
            c = -1;
            d = -1;
            if (!frz) begin
                for (int k = 0; k < N; k++) begin
                    idx = (m_ptr + k) % N;
                    if (v[idx]) begin
                        if (c < 0) c = idx;
                        else if (d < 0 && rq[idx].addr != rq[c].addr) d = idx;
                    end
                end
            end
            if (c >= 0) exp_rdy[c] = 1'b1;
            if (d >= 0) exp_rdy[d] = 1'b1;
            n_cmp++; if (bus.req_ready !== exp_rdy) begin n_err++; $display("FAIL rnd_ready cyc%0d: got %b want %b", cyc, bus.req_ready, exp_rdy); end
`ifdef REGFILE_WSCHED_STATS_EN
            if (!frz && (v & ~exp_rdy) != '0) m_stall = m_stall + 32'd1;
`endif
            if (!frz) begin
                m_c.we = (c >= 0);
                m_d.we = (d >= 0);
                if (c >= 0) begin m_c.addr = rq[c].addr; m_c.data = rq[c].data; end
                if (d >= 0) begin m_d.addr = rq[d].addr; m_d.data = rq[d].data; end
                if (d >= 0)      m_ptr = (d + 1) % N;
                else if (c >= 0) m_ptr = (c + 1) % N;
            end
            tick();
            v = v & ~exp_rdy;
            for (int r = 0; r < 16; r++) m_pend[r] = (m_c.we && m_c.addr == r) || (m_d.we && m_d.addr == r);
            n_cmp++; if (bus.port_c_we !== m_c.we || bus.port_c_write_addr !== m_c.addr || bus.port_c_in !== m_c.data) begin n_err++; $display("FAIL rnd_port_c cyc%0d: got we=%b addr=%0d want we=%b addr=%0d", cyc, bus.port_c_we, bus.port_c_write_addr, m_c.we, m_c.addr); end
            n_cmp++; if (bus.port_d_we !== m_d.we || bus.port_d_write_addr !== m_d.addr || bus.port_d_in !== m_d.data) begin n_err++; $display("FAIL rnd_port_d cyc%0d: got we=%b addr=%0d want we=%b addr=%0d", cyc, bus.port_d_we, bus.port_d_write_addr, m_d.we, m_d.addr); end
            n_cmp++; if (pending_mask !== m_pend) begin n_err++; $display("FAIL rnd_pending cyc%0d: got %h want %h", cyc, pending_mask, m_pend); end
            n_cmp++; if (stall_cycles !== m_stall) begin n_err++; $display("FAIL rnd_stall cyc%0d: got %0d want %0d", cyc, stall_cycles, m_stall); end
        end
        freeze = 1'b0;
        clear_reqs();
    endtask

    initial begin
        reset  = 1'b1;
        freeze = 1'b0;
        clear_reqs();
        test_reset();
        test_four_way();
        test_same_addr();
        test_freeze();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
